// File: rtl/mic1_ctrl_pkg.sv
// Shared types for the MIC-1 execution sequencer: FSM states, WAIT mode and
// front-panel command priority.
package mic1_ctrl_pkg;

    typedef enum logic [2:0] {
        RSTSEQ = 3'd0,
        IDLE   = 3'd1,
        RUN    = 3'd2,
        WAIT   = 3'd3,
        HALT   = 3'd4
    } exec_state_t;

    typedef enum logic {
        ModeStep = 1'b0,
        ModeRun  = 1'b1
    } wait_mode_t;

    // Encoding doubles as priority: a larger value wins when edges coincide.
    typedef enum logic [2:0] {
        CmdNone  = 3'd0,
        CmdRun   = 3'd1,
        CmdStep  = 3'd2,
        CmdStop  = 3'd3,
        CmdClear = 3'd4
    } cmd_t;

    function automatic cmd_t resolve_cmd(input logic clr, input logic stp, input logic stepb,
                                         input logic run);
        if (clr) return CmdClear;
        if (stp) return CmdStop;
        if (stepb) return CmdStep;
        if (run) return CmdRun;
        return CmdNone;
    endfunction

endpackage

// File: rtl/mic1_exec_ctrl_if.sv
// Handshake between the execution sequencer (master) and the MIC-1 datapath (slave).
interface mic1_exec_ctrl_if #(
    parameter int unsigned MPC_W = 9
);
    logic [MPC_W-1:0] mpc;
    logic             mic1_halt;
    logic             mic1_done;
    logic             mic1_ce;
    logic             mic1_rst;

    modport master (
        output mic1_ce, mic1_rst,
        input  mpc, mic1_halt, mic1_done
    );

    modport slave (
        input  mic1_ce, mic1_rst,
        output mpc, mic1_halt, mic1_done
    );
endinterface

// File: rtl/mic1_btn_edge.sv
// Rising-edge detector for a debounced button; history resets high so a button
// held through reset does not register as a press.
module mic1_btn_edge (
    input  logic clk,
    input  logic resetn,
    input  logic btn_i,
    output logic edge_o
);
    logic btn_q;

    always_ff @(posedge clk) begin
        if (resetn) btn_q <= 1'b1;
        else        btn_q <= btn_i;
    end

    assign edge_o = btn_i & ~btn_q;
endmodule

// File: rtl/mic1_exec_ctrl.sv
// MIC-1 execution sequencer: turns front-panel commands into one clock-enable per
// microinstruction, tracks completion, breakpoints, halts and datapath timeouts.
module mic1_exec_ctrl
    import mic1_ctrl_pkg::*;
#(
    parameter int unsigned MPC_W      = 9,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned RATE_W     = 24,
    parameter int unsigned TO_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              btn_run,
    input  logic              btn_stop,
    input  logic              btn_step,
    input  logic              btn_clear,
    input  logic [RATE_W-1:0] rate_div,
    input  logic              bp_en,
    input  logic [MPC_W-1:0]  bp_addr,
    mic1_exec_ctrl_if.master  dp,
    output logic              led_run_status,
    output logic              led_idle,
    output logic              led_halt,
    output logic              fault,
    output logic [CNT_W-1:0]  cycle_count
);
    localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned ToW  = $clog2(TO_CYCLES + 1);

    logic run_e, stop_e, step_e, clr_e;

    mic1_btn_edge u_edge_run   (.clk(clk), .resetn(resetn), .btn_i(btn_run),   .edge_o(run_e));
    mic1_btn_edge u_edge_stop  (.clk(clk), .resetn(resetn), .btn_i(btn_stop),  .edge_o(stop_e));
    mic1_btn_edge u_edge_step  (.clk(clk), .resetn(resetn), .btn_i(btn_step),  .edge_o(step_e));
    mic1_btn_edge u_edge_clear (.clk(clk), .resetn(resetn), .btn_i(btn_clear), .edge_o(clr_e));

    exec_state_t       state_q, state_d;
    wait_mode_t        mode_q, mode_d;
    logic              stop_pend_q, stop_pend_d;
    logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [RATE_W-1:0] div_q, div_d;
    logic [ToW-1:0]    to_cnt_q, to_cnt_d;
    logic              ce_q, ce_d, rst_q, rst_d, fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              led_run_q, led_run_d, led_idle_q, led_idle_d, led_halt_q, led_halt_d;
    cmd_t              cmd;
    logic              done_ok, bp_hit;

    assign cmd     = resolve_cmd(clr_e, stop_e, step_e, run_e);
    // The ce cycle itself never counts as completion.
    assign done_ok = dp.mic1_done & ~ce_q;
    assign bp_hit  = bp_en && (dp.mpc == bp_addr);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        stop_pend_d = stop_pend_q;
        rst_cnt_d   = rst_cnt_q;
        div_d       = div_q;
        to_cnt_d    = to_cnt_q;
        ce_d        = 1'b0;
        rst_d       = 1'b0;
        fault_d     = fault_q;
        cnt_d       = cnt_q;
        if (cmd == CmdClear) begin
            state_d     = RSTSEQ;
            rst_d       = 1'b1;
            rst_cnt_d   = '0;
            cnt_d       = '0;
            fault_d     = 1'b0;
            stop_pend_d = 1'b0;
        end else begin
            unique case (state_q)
                RSTSEQ: begin
                    if (rst_cnt_q == RstW'(RST_CYCLES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        rst_d     = 1'b1;
                        rst_cnt_d = rst_cnt_q + RstW'(1);
                    end
                end
                IDLE, HALT: begin
                    if (cmd == CmdRun) begin
                        state_d = RUN;
                        div_d   = rate_div;
                    end else if (cmd == CmdStep) begin
                        ce_d     = 1'b1;
                        state_d  = WAIT;
                        mode_d   = ModeStep;
                        to_cnt_d = '0;
                    end else if (cmd == CmdStop && state_q == HALT) begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (cmd == CmdStop) begin
                        state_d = IDLE;
                    end else if (div_q == '0) begin
                        ce_d     = 1'b1;
                        state_d  = WAIT;
                        mode_d   = ModeRun;
                        to_cnt_d = '0;
                    end else begin
                        div_d = div_q - RATE_W'(1);
                    end
                end
                WAIT: begin
                    if (cmd == CmdStop) stop_pend_d = 1'b1;
                    if (done_ok) begin
                        cnt_d       = cnt_q + CNT_W'(1);
                        stop_pend_d = 1'b0;
                        if (dp.mic1_halt || bp_hit) begin
                            state_d = HALT;
                        end else if (mode_q == ModeStep || stop_pend_q || cmd == CmdStop) begin
                            state_d = IDLE;
                        end else begin
                            state_d = RUN;
                            div_d   = rate_div;
                        end
                    end else if (to_cnt_q == ToW'(TO_CYCLES)) begin
                        fault_d     = 1'b1;
                        stop_pend_d = 1'b0;
                        state_d     = HALT;
                    end else begin
                        to_cnt_d = to_cnt_q + ToW'(1);
                    end
                end
                default: begin
                    state_d   = RSTSEQ;
                    rst_d     = 1'b1;
                    rst_cnt_d = '0;
                end
            endcase
        end
        led_idle_d = (state_d == IDLE);
        led_halt_d = (state_d == HALT);
        led_run_d  = (state_d == RUN) || (state_d == WAIT && mode_d == ModeRun);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q     <= RSTSEQ;
            mode_q      <= ModeStep;
            stop_pend_q <= 1'b0;
            rst_cnt_q   <= '0;
            div_q       <= '0;
            to_cnt_q    <= '0;
            ce_q        <= 1'b0;
            rst_q       <= 1'b1;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
            led_run_q   <= 1'b0;
            led_idle_q  <= 1'b0;
            led_halt_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            stop_pend_q <= stop_pend_d;
            rst_cnt_q   <= rst_cnt_d;
            div_q       <= div_d;
            to_cnt_q    <= to_cnt_d;
            ce_q        <= ce_d;
            rst_q       <= rst_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
            led_run_q   <= led_run_d;
            led_idle_q  <= led_idle_d;
            led_halt_q  <= led_halt_d;
        end
    end

    assign dp.mic1_ce     = ce_q;
    assign dp.mic1_rst    = rst_q;
    assign led_run_status = led_run_q;
    assign led_idle       = led_idle_q;
    assign led_halt       = led_halt_q;
    assign fault          = fault_q;
    assign cycle_count    = cnt_q;
endmodule

// File: tb/tb_mic1_exec_ctrl.sv
// Directed bench for mic1_exec_ctrl with a small datapath responder that answers
// each ce with a done pulse after a programmable latency.
module tb_mic1_exec_ctrl;
    localparam int unsigned CntW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            resetn, btn_run, btn_stop, btn_step, btn_clear, bp_en;
    logic [23:0]     rate_div;
    logic [8:0]      bp_addr;
    logic            led_run_status, led_idle, led_halt, fault;
    logic [CntW-1:0] cycle_count;

    mic1_exec_ctrl_if #(.MPC_W(9)) dp ();

    mic1_exec_ctrl #(.CNT_W(CntW)) dut (
        .clk(clk), .resetn(resetn), .btn_run(btn_run), .btn_stop(btn_stop),
        .btn_step(btn_step), .btn_clear(btn_clear), .rate_div(rate_div), .bp_en(bp_en),
        .bp_addr(bp_addr), .dp(dp), .led_run_status(led_run_status), .led_idle(led_idle),
        .led_halt(led_halt), .fault(fault), .cycle_count(cycle_count)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, ce_count = 0, done_count = 0, last_ce_cyc = 0, last_done_cyc = 0;
    bit resp_en = 1'b1;
    int resp_lat = 1, resp_idx = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (dp.mic1_ce === 1'b1) begin ce_count++; last_ce_cyc = cyc; end
        if (dp.mic1_done === 1'b1) begin done_count++; last_done_cyc = cyc; end
    end

    // Datapath model: done pulse resp_lat cycles after ce; mpc = 0x0D + done index.
    initial begin
        dp.mic1_done = 1'b0;
        dp.mpc       = '0;
        forever begin
            @(posedge clk); #1;
            dp.mic1_done = 1'b0;
            if (dp.mic1_ce === 1'b1 && resp_en) begin
                repeat (resp_lat) @(posedge clk);
                #1;
                resp_idx++;
                dp.mpc       = 9'h00D + 9'(resp_idx);
                dp.mic1_done = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press(input logic [3:0] m);
        {btn_clear, btn_stop, btn_step, btn_run} = m;
        tick();
        {btn_clear, btn_stop, btn_step, btn_run} = 4'b0000;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (led_idle !== 1'b1 && n < lim) begin tick(); n++; end
    endtask

    task automatic wait_halt(input int lim);
        int n = 0;
        while (led_halt !== 1'b1 && n < lim) begin tick(); n++; end
    endtask

    task automatic do_clear();
        press(4'b1000);
        wait_idle(20);
    endtask

    task automatic test_reset();
        int n = 0;
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        n_cmp++; if (led_idle !== 1'b0) begin n_bad++; $display("FAIL reset_idle: got %b want 0", led_idle); end
        while (dp.mic1_rst === 1'b1 && n < 20) begin n++; tick(); end
        n_cmp++; if (n != 4) begin n_bad++; $display("FAIL reset_len: got %0d want 4", n); end
        n_cmp++; if (led_idle !== 1'b1) begin n_bad++; $display("FAIL reset_to_idle: got %b want 1", led_idle); end
        n_cmp++; if (cycle_count !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", cycle_count); end
        n_cmp++; if (ce_count != 0) begin n_bad++; $display("FAIL reset_ce: got %0d want 0", ce_count); end
        n_cmp++; if ({fault, led_halt, led_run_status} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000", {fault, led_halt, led_run_status}); end
    endtask

    task automatic test_step();
        int ce0 = ce_count;
        press(4'b0100);
        tick(3);
        n_cmp++; if (led_idle !== 1'b1 || ce_count != ce0) begin
            n_bad++; $display("FAIL idle_stop: got idle=%b ce=%0d want idle=1 ce=%0d", led_idle, ce_count, ce0); end
        resp_lat = 3;
        press(4'b0010);
        n_cmp++; if (dp.mic1_ce !== 1'b1 || led_run_status !== 1'b0) begin
            n_bad++; $display("FAIL step_ce: got ce=%b run=%b want ce=1 run=0", dp.mic1_ce, led_run_status); end
        wait_idle(50);
        n_cmp++; if (ce_count - ce0 != 1) begin n_bad++; $display("FAIL step_ce_cnt: got %0d want 1", ce_count - ce0); end
        n_cmp++; if (cycle_count !== 4'd1) begin n_bad++; $display("FAIL step_cnt: got %0d want 1", cycle_count); end
        n_cmp++; if (led_idle !== 1'b1) begin n_bad++; $display("FAIL step_idle: got %b want 1", led_idle); end
        n_cmp++; if (last_done_cyc - last_ce_cyc != 3) begin
            n_bad++; $display("FAIL step_lat: got %0d want 3", last_done_cyc - last_ce_cyc); end
    endtask

    task automatic test_run();
        int ce0, d0, c1, n;
        for (int r = 0; r < 2; r++) begin
            do_clear();
            rate_div = (r == 0) ? 24'd0 : 24'd2;
            resp_lat = 1;
            ce0 = ce_count;
            d0  = done_count;
            press(4'b0001);
            n_cmp++; if (led_run_status !== 1'b1) begin n_bad++; $display("FAIL run_led: got %b want 1", led_run_status); end
            n = 0;
            while (done_count - d0 < 3 && n < 200) begin tick(); n++; end
            c1 = ce_count;
            n  = 0;
            while (ce_count == c1 && n < 50) begin tick(); n++; end
            n_cmp++; if (last_ce_cyc - last_done_cyc != 2 + r * 2) begin
                n_bad++; $display("FAIL run_gap%0d: got %0d want %0d", r, last_ce_cyc - last_done_cyc, 2 + r * 2); end
            n = 0;
            while (done_count - d0 < 10 && n < 500) begin tick(); n++; end
            press(4'b0100);
            wait_idle(50);
            n_cmp++; if (led_idle !== 1'b1) begin n_bad++; $display("FAIL run_stop_idle: got %b want 1", led_idle); end
            if (r == 0) begin
                n_cmp++; if (cycle_count !== 4'd10 && cycle_count !== 4'd11) begin
                    n_bad++; $display("FAIL run_cnt: got %0d want 10 or 11", cycle_count); end
            end
            n_cmp++; if (ce_count - ce0 != int'(cycle_count) || done_count - d0 != int'(cycle_count)) begin
                n_bad++; $display("FAIL run_inflight: got ce=%0d done=%0d want %0d", ce_count - ce0,
                                  done_count - d0, cycle_count); end
            c1 = ce_count;
            tick(20);
            n_cmp++; if (ce_count != c1) begin n_bad++; $display("FAIL run_no_ce: got %0d want %0d", ce_count, c1); end
        end
        rate_div = 24'd0;
    endtask

    task automatic test_breakpoint();
        int ce0, c1, n;
        do_clear();
        resp_idx = 0;
        bp_en    = 1'b1;
        bp_addr  = 9'h012;
        ce0      = ce_count;
        press(4'b0001);
        wait_halt(300);
        n_cmp++; if (led_halt !== 1'b1 || led_run_status !== 1'b0) begin
            n_bad++; $display("FAIL bp_halt: got halt=%b run=%b want 1 0", led_halt, led_run_status); end
        n_cmp++; if (cycle_count !== 4'd5) begin n_bad++; $display("FAIL bp_cnt: got %0d want 5", cycle_count); end
        n_cmp++; if (ce_count - ce0 != 5) begin n_bad++; $display("FAIL bp_ce: got %0d want 5", ce_count - ce0); end
        c1 = ce_count;
        press(4'b0001);
        n = 0;
        while (ce_count == c1 && n < 10) begin tick(); n++; end
        n_cmp++; if (n != 2) begin n_bad++; $display("FAIL bp_resume: got %0d want 2", n); end
        tick(3);
        n_cmp++; if (led_halt !== 1'b0) begin n_bad++; $display("FAIL bp_rehit: got %b want 0", led_halt); end
        bp_en = 1'b0;
        press(4'b0100);
        wait_idle(50);
        n_cmp++; if (led_idle !== 1'b1) begin n_bad++; $display("FAIL bp_stop: got %b want 1", led_idle); end
    endtask

    task automatic test_halt();
        do_clear();
        dp.mic1_halt = 1'b1;
        press(4'b0010);
        wait_halt(20);
        n_cmp++; if (led_halt !== 1'b1 || fault !== 1'b0 || cycle_count !== 4'd1) begin
            n_bad++; $display("FAIL uhalt: got halt=%b fault=%b cnt=%0d want 1 0 1", led_halt, fault, cycle_count); end
        dp.mic1_halt = 1'b0;
        press(4'b0100);
        n_cmp++; if (led_idle !== 1'b1) begin n_bad++; $display("FAIL uhalt_stop: got %b want 1", led_idle); end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_clear();
        resp_en = 1'b0;
        press(4'b0010);
        while (led_halt !== 1'b1 && n < 2000) begin tick(); n++; end
        n_cmp++; if (n != 1025) begin n_bad++; $display("FAIL to_len: got %0d want 1025", n); end
        n_cmp++; if (fault !== 1'b1 || cycle_count !== '0) begin
            n_bad++; $display("FAIL to_fault: got fault=%b cnt=%0d want 1 0", fault, cycle_count); end
        press(4'b1000);
        n_cmp++; if (dp.mic1_rst !== 1'b1 || fault !== 1'b0 || led_halt !== 1'b0) begin
            n_bad++; $display("FAIL to_clear: got rst=%b fault=%b halt=%b want 1 0 0", dp.mic1_rst, fault, led_halt); end
        resp_en = 1'b1;
        wait_idle(20);
    endtask

    task automatic test_back_to_back();
        int ce0;
        do_clear();
        resp_lat = 1;
        press(4'b0010);
        wait_idle(20);
        resp_lat = 5;
        ce0 = ce_count;
        press(4'b0010);
        tick();
        press(4'b1101);
        n_cmp++; if (dp.mic1_rst !== 1'b1 || dp.mic1_ce !== 1'b0) begin
            n_bad++; $display("FAIL b2b_rst: got rst=%b ce=%b want 1 0", dp.mic1_rst, dp.mic1_ce); end
        n_cmp++; if (cycle_count !== '0 || led_run_status !== 1'b0) begin
            n_bad++; $display("FAIL b2b_cnt: got cnt=%0d run=%b want 0 0", cycle_count, led_run_status); end
        tick(10);
        n_cmp++; if (ce_count != ce0 + 1 || led_idle !== 1'b1) begin
            n_bad++; $display("FAIL b2b_after: got ce=%0d idle=%b want %0d 1", ce_count, led_idle, ce0 + 1); end
        resp_lat = 1;
    endtask

    task automatic test_wrap();
        do_clear();
        resp_lat = 1;
        for (int i = 0; i < 15; i++) begin press(4'b0010); wait_idle(20); end
        n_cmp++; if (cycle_count !== 4'hF) begin n_bad++; $display("FAIL wrap_full: got %0d want 15", cycle_count); end
        press(4'b0010);
        wait_idle(20);
        n_cmp++; if (cycle_count !== 4'h0 || led_idle !== 1'b1) begin
            n_bad++; $display("FAIL wrap_zero: got cnt=%0d idle=%b want 0 1", cycle_count, led_idle); end
    endtask

    initial begin
        {btn_clear, btn_stop, btn_step, btn_run} = 4'b0000;
        rate_div     = 24'd0;
        bp_en        = 1'b0;
        bp_addr      = 9'h000;
        dp.mic1_halt = 1'b0;
        test_reset();
        test_step();
        test_run();
        test_breakpoint();
        test_halt();
        test_timeout();
        test_back_to_back();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
